// File: rtl/sram_ctrl_pkg.sv
// Shared types, default geometry and strobe counter sizing for the 1024x8 SRAM controller.
package sram_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    STROBE = 2'd2,
    HOLD   = 2'd3
  } state_e;

  localparam int ADDR_W_DEF      = 10;
  localparam int DATA_W_DEF      = 8;
  localparam int WAIT_CYCLES_DEF = 2;
  localparam int CNT_W           = 4;

  // Counter preload so the STROBE phase lasts exactly wait_cycles clocks.
  function automatic logic [CNT_W-1:0] strobe_load(input int wait_cycles);
    return CNT_W'(wait_cycles - 1);
  endfunction

endpackage

// File: rtl/sram_ctrl_1024x8_bus_io.sv
// Registered output enable and data for the shared SRAM bus, plus the raw input sample path.
module sram_bus_io #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              oe_d,
  input  logic [DATA_W-1:0] wdata_d,
  output logic              oe,
  output logic [DATA_W-1:0] rdata,
  inout  wire  [DATA_W-1:0] sram_data
);

  logic              oe_q;
  logic [DATA_W-1:0] dout_q;

  // Reset releases the bus immediately, even in the middle of a write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      oe_q   <= 1'b0;
      dout_q <= '0;
    end else begin
      oe_q   <= oe_d;
      dout_q <= wdata_d;
    end
  end

  assign sram_data = oe_q ? dout_q : {DATA_W{1'bz}};
  assign rdata     = sram_data;
  assign oe        = oe_q;

endmodule

// File: rtl/sram_ctrl_1024x8.sv
// Clocked valid/ready front end for the 1024x8 asynchronous SRAM macro.
// Optional write read-back check with sticky wr_err port: define SRAM_CTRL_READBACK_EN.
module sram_ctrl_1024x8
  import sram_ctrl_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int WAIT_CYCLES = WAIT_CYCLES_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
`ifdef SRAM_CTRL_READBACK_EN
  output logic              wr_err,
`endif
  output logic [ADDR_W-1:0] sram_addr,
  inout  wire  [DATA_W-1:0] sram_data,
  output logic              sram_rw,
  output logic              sram_cs
);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ready_q, ready_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic [ADDR_W-1:0] sram_addr_q, sram_addr_d;
  logic              sram_rw_q, sram_rw_d;
  logic              sram_cs_q, sram_cs_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              oe_d;
  logic              bus_oe;
  logic [DATA_W-1:0] bus_rdata;
  logic              accept;
  logic              last_strobe;
  logic              rb_q;

`ifdef SRAM_CTRL_READBACK_EN
  logic rb_d;
  logic err_q, err_d;
`else
  assign rb_q = 1'b0;
`endif

  assign accept      = (state_q == IDLE) && ready_q && req_valid;
  assign last_strobe = (state_q == STROBE) && (cnt_q == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // A pending read-back takes priority over new requests while in IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept || rb_q) state_d = SETUP;
      SETUP:   state_d = STROBE;
      STROBE:  if (cnt_q == '0) state_d = HOLD;
      HOLD:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d       = cnt_q;
    sram_addr_d = sram_addr_q;
    sram_rw_d   = sram_rw_q;
    wdata_d     = wdata_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_valid_d = 1'b0;
    if (accept) begin
      sram_addr_d = req_addr;
      sram_rw_d   = req_write;
      wdata_d     = req_wdata;
    end
    if (state_q == SETUP)                        cnt_d = strobe_load(WAIT_CYCLES);
    else if (state_q == STROBE && cnt_q != '0)   cnt_d = cnt_q - CNT_W'(1);
    if (last_strobe && !sram_rw_q && !rb_q) begin
      rsp_rdata_d = bus_rdata;
      rsp_valid_d = 1'b1;
    end
`ifdef SRAM_CTRL_READBACK_EN
    rb_d  = rb_q;
    err_d = err_q;
    // Leaving a write's HOLD turns the bus around and queues the verify read.
    if (state_q == HOLD) rb_d = sram_rw_q;
    if (state_q == HOLD && sram_rw_q) sram_rw_d = 1'b0;
    if (last_strobe && rb_q && (bus_rdata != wdata_q)) err_d = 1'b1;
    ready_d = (state_d == IDLE) && !rb_d;
`else
    ready_d = (state_d == IDLE);
`endif
    sram_cs_d = (state_d == STROBE);
    oe_d      = sram_rw_d && (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q       <= '0;
      ready_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      sram_addr_q <= '0;
      sram_rw_q   <= 1'b0;
      sram_cs_q   <= 1'b0;
      wdata_q     <= '0;
    end else begin
      cnt_q       <= cnt_d;
      ready_q     <= ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      sram_addr_q <= sram_addr_d;
      sram_rw_q   <= sram_rw_d;
      sram_cs_q   <= sram_cs_d;
      wdata_q     <= wdata_d;
    end
  end

`ifdef SRAM_CTRL_READBACK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rb_q  <= 1'b0;
      err_q <= 1'b0;
    end else begin
      rb_q  <= rb_d;
      err_q <= err_d;
    end
  end

  assign wr_err = err_q;
`endif

  sram_bus_io #(.DATA_W(DATA_W)) u_bus_io (
    .clk       (clk),
    .rst       (rst),
    .oe_d      (oe_d),
    .wdata_d   (wdata_d),
    .oe        (bus_oe),
    .rdata     (bus_rdata),
    .sram_data (sram_data)
  );

  assign req_ready = ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign sram_addr = sram_addr_q;
  assign sram_rw   = sram_rw_q;
  assign sram_cs   = sram_cs_q;

  a_oe_only_on_write: assert property (@(posedge clk) disable iff (rst) !(bus_oe && !sram_rw_q));
  a_rw_stable_in_cs:  assert property (@(posedge clk) disable iff (rst) sram_cs_q |-> $stable(sram_rw_q));
  a_addr_stable_in_cs: assert property (@(posedge clk) disable iff (rst) sram_cs_q |-> $stable(sram_addr_q));

endmodule

// File: tb/tb_sram_ctrl_1024x8.sv
// Self-checking bench for sram_ctrl_1024x8 with an async SRAM model and an ideal memory reference.
module tb_sram_ctrl_1024x8;

  localparam int W = 2;
`ifdef SRAM_CTRL_READBACK_EN
  localparam int WR_BUSY = 2 * (W + 3) - 1;
`else
  localparam int WR_BUSY = W + 2;
`endif

  logic       clk       = 1'b0;
  logic       rst       = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_write = 1'b0;
  logic [9:0] req_addr  = '0;
  logic [7:0] req_wdata = '0;
  logic       req_ready;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic [9:0] sram_addr;
  logic       sram_rw;
  logic       sram_cs;
  wire  [7:0] sram_data;
`ifdef SRAM_CTRL_READBACK_EN
  logic       wr_err;
`endif

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int contention = 0;

  logic [7:0] sram_mem [1024];
  logic [7:0] stuck0_mask = 8'h00;
  logic [7:0] ref_mem [1024];
  logic [9:0] written [$];

  sram_ctrl_1024x8 #(.ADDR_W(10), .DATA_W(8), .WAIT_CYCLES(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
`ifdef SRAM_CTRL_READBACK_EN
    .wr_err    (wr_err),
`endif
    .sram_addr (sram_addr),
    .sram_data (sram_data),
    .sram_rw   (sram_rw),
    .sram_cs   (sram_cs)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Asynchronous SRAM: drives while selected for read, stores while selected for write.
  assign sram_data = (sram_cs && !sram_rw) ? sram_mem[sram_addr] : 8'bz;

  always @(posedge clk) begin
    if (sram_cs && sram_rw) sram_mem[sram_addr] <= sram_data & ~stuck0_mask;
  end

  always @(negedge clk) begin
    if (!rst && dut.bus_oe === 1'b1 && sram_cs === 1'b1 && sram_rw === 1'b0) contention++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic w, input logic [9:0] a, input logic [7:0] d);
    int g;
    g = 0;
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    req_wdata = d;
    while (req_ready !== 1'b1 && g < 100) begin
      tick();
      g++;
    end
    if (g >= 100) begin
      total++;
      bad++;
      $display("[TB] FAIL issue_timeout: req_ready=%b required=1", req_ready);
    end
    tick();
    req_valid = 1'b0;
    if (w) ref_mem[a] = d;
  endtask

  task automatic wait_rsp(output logic [7:0] d, output int lat);
    d   = 'x;
    lat = -1;
    for (int k = 0; k < 40; k++) begin
      if (rsp_valid === 1'b1) begin
        lat = k;
        d   = rsp_rdata;
        break;
      end
      tick();
    end
  endtask

  task automatic do_read(input logic [9:0] a, output logic [7:0] d, output int lat);
    issue(1'b0, a, 8'h00);
    wait_rsp(d, lat);
  endtask

  task automatic wait_idle();
    int g;
    g = 0;
    while (req_ready !== 1'b1 && g < 100) begin
      tick();
      g++;
    end
    total++;
    if (req_ready !== 1'b1) begin
      bad++;
      $display("[TB] FAIL idle_timeout: req_ready=%b required=1", req_ready);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({req_ready, rsp_valid, sram_cs, sram_rw, dut.bus_oe} !== 5'b0 || sram_addr !== 10'h000 || rsp_rdata !== 8'h00) begin
      bad++;
      $display("[TB] FAIL reset_values: ready=%b rsp_valid=%b cs=%b rw=%b oe=%b addr=%h rdata=%h required all zero",
               req_ready, rsp_valid, sram_cs, sram_rw, dut.bus_oe, sram_addr, rsp_rdata);
    end
`ifdef SRAM_CTRL_READBACK_EN
    total++;
    if (wr_err !== 1'b0) begin
      bad++;
      $display("[TB] FAIL reset_wr_err: got=%b required=0", wr_err);
    end
`endif
    rst = 1'b0;
    tick();
    total++;
    if (req_ready !== 1'b1) begin
      bad++;
      $display("[TB] FAIL ready_after_reset: got=%b required=1", req_ready);
    end
  endtask

  task automatic test_write_timing();
    int cs_count;
    cs_count = 0;
    issue(1'b1, 10'h3FF, 8'hA5);
    for (int k = 0; k <= W + 1; k++) begin
      total++;
      if (sram_cs !== ((k >= 1) && (k <= W)) || sram_rw !== 1'b1 || dut.bus_oe !== 1'b1 ||
          sram_data !== 8'hA5 || sram_addr !== 10'h3FF || req_ready !== 1'b0) begin
        bad++;
        $display("[TB] FAIL write_phase k=%0d: cs=%b rw=%b oe=%b data=%h addr=%h ready=%b required cs=%b rw=1 oe=1 data=a5 addr=3ff ready=0",
                 k, sram_cs, sram_rw, dut.bus_oe, sram_data, sram_addr, req_ready, (k >= 1) && (k <= W));
      end
      if (sram_cs === 1'b1) cs_count++;
      tick();
    end
    total++;
    if (cs_count != W || dut.bus_oe !== 1'b0) begin
      bad++;
      $display("[TB] FAIL write_strobe: cs_cycles=%0d oe_after_hold=%b required cs_cycles=%0d oe=0", cs_count, dut.bus_oe, W);
    end
    for (int k = W + 2; k < WR_BUSY; k++) begin
      total++;
      if (req_ready !== 1'b0) begin
        bad++;
        $display("[TB] FAIL write_busy k=%0d: ready=%b required=0", k, req_ready);
      end
      tick();
    end
    total++;
    if (req_ready !== 1'b1) begin
      bad++;
      $display("[TB] FAIL write_ready_return: ready=%b required=1 at %0d clocks", req_ready, WR_BUSY);
    end
  endtask

  task automatic test_read();
    logic exp_v;
    issue(1'b0, 10'h3FF, 8'h00);
    for (int k = 0; k <= W + 2; k++) begin
      exp_v = (k == W + 1);
      total++;
      if (rsp_valid !== exp_v || dut.bus_oe !== 1'b0 || (exp_v && rsp_rdata !== ref_mem[10'h3FF])) begin
        bad++;
        $display("[TB] FAIL read_phase k=%0d: rsp_valid=%b oe=%b rdata=%h required rsp_valid=%b oe=0 rdata=%h",
                 k, rsp_valid, dut.bus_oe, rsp_rdata, exp_v, ref_mem[10'h3FF]);
      end
      tick();
    end
    total++;
    if (rsp_rdata !== 8'hA5 || req_ready !== 1'b1) begin
      bad++;
      $display("[TB] FAIL read_hold: rdata=%h ready=%b required rdata=a5 ready=1", rsp_rdata, req_ready);
    end
  endtask

  task automatic test_back_to_back();
    int a1, a2, lat;
    logic [7:0] d;
    issue(1'b1, 10'h000, 8'h12);
    a1 = cyc;
    issue(1'b0, 10'h000, 8'h00);
    a2 = cyc;
    total++;
    if (a2 - a1 != WR_BUSY + 1) begin
      bad++;
      $display("[TB] FAIL b2b_spacing: got=%0d required=%0d", a2 - a1, WR_BUSY + 1);
    end
    wait_rsp(d, lat);
    total++;
    if (d !== 8'h12 || lat != W + 1) begin
      bad++;
      $display("[TB] FAIL b2b_read: rdata=%h latency=%0d required rdata=12 latency=%0d", d, lat, W + 1);
    end
  endtask

  task automatic test_boundaries();
    logic [7:0] v0, v1, d;
    int lat;
    v0 = 8'($urandom);
    v1 = ~v0;
    issue(1'b1, 10'h000, v0);
    issue(1'b1, 10'h3FF, v1);
    do_read(10'h000, d, lat);
    total++;
    if (d !== v0 || lat != W + 1) begin
      bad++;
      $display("[TB] FAIL boundary_low: rdata=%h latency=%0d required rdata=%h latency=%0d", d, lat, v0, W + 1);
    end
    do_read(10'h3FF, d, lat);
    total++;
    if (d !== v1 || lat != W + 1) begin
      bad++;
      $display("[TB] FAIL boundary_high: rdata=%h latency=%0d required rdata=%h latency=%0d", d, lat, v1, W + 1);
    end
  endtask

  task automatic test_random();
    logic [9:0] a;
    logic [7:0] d;
    int lat;
    for (int i = 0; i < 24; i++) begin
      if (written.size() == 0 || $urandom_range(0, 1) == 0) begin
        a = 10'($urandom_range(0, 1023));
        d = 8'($urandom);
        issue(1'b1, a, d);
        written.push_back(a);
      end else begin
        a = written[$urandom_range(0, written.size() - 1)];
        do_read(a, d, lat);
        total++;
        if (d !== ref_mem[a] || lat != W + 1) begin
          bad++;
          $display("[TB] FAIL random_read addr=%h: rdata=%h latency=%0d required rdata=%h latency=%0d",
                   a, d, lat, ref_mem[a], W + 1);
        end
      end
    end
  endtask

  task automatic test_reset_mid_write();
    logic [7:0] d;
    int lat;
    int pulses;
    pulses = 0;
    issue(1'b1, 10'h155, 8'h3C);
    tick();
    total++;
    if (sram_cs !== 1'b1) begin
      bad++;
      $display("[TB] FAIL mid_reset_strobe: cs=%b required=1", sram_cs);
    end
    #2 rst = 1'b1;
    #1;
    total++;
    if (sram_cs !== 1'b0 || dut.bus_oe !== 1'b0 || rsp_valid !== 1'b0) begin
      bad++;
      $display("[TB] FAIL async_reset: cs=%b oe=%b rsp_valid=%b required all 0", sram_cs, dut.bus_oe, rsp_valid);
    end
    tick();
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      if (rsp_valid === 1'b1) pulses++;
    end
    total++;
    if (req_ready !== 1'b1 || pulses != 0) begin
      bad++;
      $display("[TB] FAIL after_reset: ready=%b rsp_pulses=%0d required ready=1 pulses=0", req_ready, pulses);
    end
    do_read(10'h3FF, d, lat);
    total++;
    if (d !== ref_mem[10'h3FF] || lat != W + 1) begin
      bad++;
      $display("[TB] FAIL read_after_reset: rdata=%h latency=%0d required rdata=%h latency=%0d",
               d, lat, ref_mem[10'h3FF], W + 1);
    end
  endtask

`ifdef SRAM_CTRL_READBACK_EN
  task automatic test_readback();
    issue(1'b1, 10'h0AA, 8'h5A);
    wait_idle();
    total++;
    if (wr_err !== 1'b0) begin
      bad++;
      $display("[TB] FAIL readback_clean: wr_err=%b required=0", wr_err);
    end
    stuck0_mask = 8'h08;
    issue(1'b1, 10'h0AB, 8'hFF);
    wait_idle();
    total++;
    if (wr_err !== 1'b1) begin
      bad++;
      $display("[TB] FAIL readback_stuck: wr_err=%b required=1", wr_err);
    end
    stuck0_mask = 8'h00;
    issue(1'b1, 10'h0AC, 8'h33);
    wait_idle();
    total++;
    if (wr_err !== 1'b1) begin
      bad++;
      $display("[TB] FAIL readback_sticky: wr_err=%b required=1", wr_err);
    end
  endtask
`endif

  task automatic test_no_contention();
    total++;
    if (contention != 0) begin
      bad++;
      $display("[TB] FAIL bus_contention: cycles=%0d required=0", contention);
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) begin
      sram_mem[i] = 8'h00;
      ref_mem[i]  = 8'h00;
    end
    test_reset();
    test_write_timing();
    test_read();
    test_back_to_back();
    test_boundaries();
    test_random();
    test_reset_mid_write();
`ifdef SRAM_CTRL_READBACK_EN
    test_readback();
`endif
    test_no_contention();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
